// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush; the empty stage presents NOP_VAL.
// Latency: 1 cycle from in to out, with no combinational in->out path.
// Backpressure: SKID=1 uses two entries and a registered in_ready; SKID=0 uses one entry and in_ready = out_ready | ~out_valid.
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter int               SKID    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    if (SKID != 0) begin : g_skid
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_MAIN  = 2'd1,
            ST_BOTH  = 2'd2
        } state_t;

        state_t           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_rdy_q;
        logic             accept, pop;

        assign accept = in_valid & in_rdy_q;
        assign pop    = (state_q != ST_EMPTY) & out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
                // A pop on this edge still completes downstream; only stage state is cleared.
                state_d = ST_EMPTY;
                main_d  = NOP_VAL;
                skid_d  = NOP_VAL;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            state_d = ST_MAIN;
                            main_d  = in_data;
                        end
                    end
                    ST_MAIN: begin
                        if (accept && pop) begin
                            main_d = in_data;
                        end else if (accept) begin
                            state_d = ST_BOTH;
                            skid_d  = in_data;
                        end else if (pop) begin
                            state_d = ST_EMPTY;
                            main_d  = NOP_VAL;
                        end
                    end
                    ST_BOTH: begin
                        if (pop) begin
                            state_d = ST_MAIN;
                            main_d  = skid_q;
                            skid_d  = NOP_VAL;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VAL;
                        skid_d  = NOP_VAL;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= ST_EMPTY;
                main_q   <= NOP_VAL;
                skid_q   <= NOP_VAL;
                in_rdy_q <= 1'b1;
            end else begin
                state_q  <= state_d;
                main_q   <= main_d;
                skid_q   <= skid_d;
                // Registered copy of (state != BOTH), computed from the next state.
                in_rdy_q <= (state_d != ST_BOTH);
            end
        end

        assign in_ready  = in_rdy_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_q;
        assign occupancy = (state_q == ST_BOTH) ? 2'd2 :
                           (state_q == ST_MAIN) ? 2'd1 : 2'd0;
    end else begin : g_single
        logic [WIDTH-1:0] data_q;
        logic             vld_q;
        logic             accept, pop;

        assign in_ready = out_ready | ~vld_q;
        assign accept   = in_valid & in_ready;
        assign pop      = vld_q & out_ready;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                data_q <= NOP_VAL;
                vld_q  <= 1'b0;
            end else if (accept) begin
                data_q <= in_data;
                vld_q  <= 1'b1;
            end else if (pop) begin
                data_q <= NOP_VAL;
                vld_q  <= 1'b0;
            end
        end

        assign out_valid = vld_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, vld_q};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks on 16-bit SKID=1 / SKID=0 stages, then a queue-model scoreboard
// on randomly driven 7-bit (SKID=1) and 64-bit (SKID=0) stages.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Directed DUTs
    logic        d1_vld, d1_rdy, d1_fl, d1_ir, d1_ov;
    logic [15:0] d1_din, d1_od;
    logic [1:0]  d1_occ;
    logic        d0_vld, d0_rdy, d0_fl, d0_ir, d0_ov;
    logic [15:0] d0_din, d0_od;
    logic [1:0]  d0_occ;

    // Random DUTs
    logic        r7_vld, r7_rdy, r7_fl, r7_ir, r7_ov;
    logic [6:0]  r7_din, r7_od;
    logic [1:0]  r7_occ;
    logic        r64_vld, r64_rdy, r64_fl, r64_ir, r64_ov;
    logic [63:0] r64_din, r64_od;
    logic [1:0]  r64_occ;

    logic [63:0] sb0[$];
    logic [63:0] sb1[$];

    pipe_stage_reg #(.WIDTH(16), .NOP_VAL(16'hDEAD), .SKID(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(d1_fl), .in_valid(d1_vld), .in_ready(d1_ir),
        .in_data(d1_din), .out_valid(d1_ov), .out_ready(d1_rdy), .out_data(d1_od),
        .occupancy(d1_occ));

    pipe_stage_reg #(.WIDTH(16), .NOP_VAL(16'hDEAD), .SKID(0)) u_d0 (
        .clk(clk), .rst(rst), .flush(d0_fl), .in_valid(d0_vld), .in_ready(d0_ir),
        .in_data(d0_din), .out_valid(d0_ov), .out_ready(d0_rdy), .out_data(d0_od),
        .occupancy(d0_occ));

    pipe_stage_reg #(.WIDTH(7), .NOP_VAL(7'h55), .SKID(1)) u_r7 (
        .clk(clk), .rst(rst), .flush(r7_fl), .in_valid(r7_vld), .in_ready(r7_ir),
        .in_data(r7_din), .out_valid(r7_ov), .out_ready(r7_rdy), .out_data(r7_od),
        .occupancy(r7_occ));

    pipe_stage_reg #(.WIDTH(64), .NOP_VAL(64'hDEAD_BEEF_0000_1111), .SKID(0)) u_r64 (
        .clk(clk), .rst(rst), .flush(r64_fl), .in_valid(r64_vld), .in_ready(r64_ir),
        .in_data(r64_din), .out_valid(r64_ov), .out_ready(r64_rdy), .out_data(r64_od),
        .occupancy(r64_occ));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of live entries. Checks the pre-edge outputs, then applies the edge.
    task automatic model_step(input int id, input bit skid, input logic [63:0] nop,
                              input logic [63:0] mask, input logic vld, input logic rdy,
                              input logic fl, input logic [63:0] din, input logic ov,
                              input logic [63:0] od, input logic [1:0] occ, input logic ir);
        logic [63:0] q[$];
        bit exp_ir, acc, pop;
        if (id == 0) q = sb0; else q = sb1;
        chk("rnd_occ", 64'(occ), 64'(q.size()));
        chk("rnd_out_valid", 64'(ov), 64'(q.size() != 0));
        chk("rnd_out_data", od, (q.size() != 0) ? q[0] : nop);
        exp_ir = skid ? (q.size() < 2) : (rdy || q.size() == 0);
        chk("rnd_in_ready", 64'(ir), 64'(exp_ir));
        acc = vld && exp_ir;
        pop = (q.size() != 0) && rdy;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(din & mask);
        end
        if (id == 0) sb0 = q; else sb1 = q;
    endtask

    initial begin
        rst = 1'b1;
        {d1_vld, d1_rdy, d1_fl, d0_vld, d0_rdy, d0_fl} = '0;
        {r7_vld, r7_rdy, r7_fl, r64_vld, r64_rdy, r64_fl} = '0;
        d1_din = '0; d0_din = '0; r7_din = '0; r64_din = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_d1_ov", 64'(d1_ov), 64'(0));
        chk("rst_d1_od", 64'(d1_od), 64'h0000_DEAD);
        chk("rst_d1_occ", 64'(d1_occ), 64'(0));
        chk("rst_d1_ir", 64'(d1_ir), 64'(1));
        chk("rst_d0_ov", 64'(d0_ov), 64'(0));
        chk("rst_d0_od", 64'(d0_od), 64'h0000_DEAD);

        // Reset mid-operation on the skid stage
        d1_vld = 1'b1; d1_din = 16'h000A; tick();
        d1_din = 16'h000B; tick();
        d1_vld = 1'b0;
        chk("mid_occ2", 64'(d1_occ), 64'(2));
        chk("mid_ir0", 64'(d1_ir), 64'(0));
        chk("mid_head", 64'(d1_od), 64'h000A);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_rst_ov", 64'(d1_ov), 64'(0));
        chk("mid_rst_od", 64'(d1_od), 64'h0000_DEAD);
        chk("mid_rst_occ", 64'(d1_occ), 64'(0));
        chk("mid_rst_ir", 64'(d1_ir), 64'(1));
        d1_rdy = 1'b1; tick();
        chk("mid_no_ghost", 64'(d1_ov), 64'(0));

        // Streaming 1..20 through both variants
        d0_rdy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            d1_vld = 1'b1; d1_din = 16'(i);
            d0_vld = 1'b1; d0_din = 16'(i);
            tick();
            chk("stream_d1_od", 64'(d1_od), 64'(i));
            chk("stream_d1_occ", 64'(d1_occ), 64'(1));
            chk("stream_d1_ir", 64'(d1_ir), 64'(1));
            chk("stream_d0_od", 64'(d0_od), 64'(i));
            chk("stream_d0_occ", 64'(d0_occ), 64'(1));
        end
        d1_vld = 1'b0; d0_vld = 1'b0;
        tick();
        chk("stream_d1_drain", 64'(d1_ov), 64'(0));
        chk("stream_d0_drain", 64'(d0_od), 64'h0000_DEAD);

        // Back-pressure on the skid stage
        d1_rdy = 1'b0;
        d1_vld = 1'b1; d1_din = 16'h0011; tick();
        d1_din = 16'h0022; tick();
        chk("bp_ir0", 64'(d1_ir), 64'(0));
        d1_din = 16'h0033; tick();
        chk("bp_occ2", 64'(d1_occ), 64'(2));
        chk("bp_stable", 64'(d1_od), 64'h0011);
        d1_rdy = 1'b1; tick();
        chk("bp_second", 64'(d1_od), 64'h0022);
        chk("bp_ir1", 64'(d1_ir), 64'(1));
        tick();
        d1_vld = 1'b0;
        chk("bp_third", 64'(d1_od), 64'h0033);
        chk("bp_third_occ", 64'(d1_occ), 64'(1));
        tick();
        chk("bp_empty", 64'(d1_ov), 64'(0));

        // Flush with a coinciding accept
        d1_rdy = 1'b0;
        d1_vld = 1'b1; d1_din = 16'h0055; tick();
        chk("fl_hold", 64'(d1_od), 64'h0055);
        d1_fl = 1'b1; d1_din = 16'h0066; tick();
        d1_fl = 1'b0; d1_vld = 1'b0;
        chk("fl_ov", 64'(d1_ov), 64'(0));
        chk("fl_od", 64'(d1_od), 64'h0000_DEAD);
        chk("fl_occ", 64'(d1_occ), 64'(0));
        chk("fl_ir", 64'(d1_ir), 64'(1));
        d1_rdy = 1'b1; tick();
        chk("fl_no_66", 64'(d1_ov), 64'(0));

        // SKID=0 combinational in_ready
        d0_rdy = 1'b0;
        d0_vld = 1'b1; d0_din = 16'h0070; tick();
        d0_vld = 1'b0;
        #1;
        chk("comb_ir0", 64'(d0_ir), 64'(0));
        d0_rdy = 1'b1; d0_vld = 1'b1; d0_din = 16'h0077;
        #1;
        chk("comb_ir1", 64'(d0_ir), 64'(1));
        tick();
        d0_vld = 1'b0;
        chk("comb_77", 64'(d0_od), 64'h0077);
        d0_fl = 1'b1; tick();
        d0_fl = 1'b0;
        chk("comb_flush", 64'(d0_ov), 64'(0));

        // Random traffic against the scoreboard
        sb0.delete();
        sb1.delete();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            r7_vld  = ($urandom_range(0, 99) < 60);
            r7_rdy  = ($urandom_range(0, 99) < 55);
            r7_fl   = ($urandom_range(0, 99) < 3);
            r7_din  = 7'($urandom);
            r64_vld = ($urandom_range(0, 99) < 60);
            r64_rdy = ($urandom_range(0, 99) < 55);
            r64_fl  = ($urandom_range(0, 99) < 3);
            r64_din = {$urandom, $urandom};
            #1;
            model_step(0, 1'b1, 64'h55, 64'h7F, r7_vld, r7_rdy, r7_fl, 64'(r7_din),
                       r7_ov, 64'(r7_od), r7_occ, r7_ir);
            model_step(1, 1'b0, 64'hDEAD_BEEF_0000_1111, '1, r64_vld, r64_rdy, r64_fl,
                       r64_din, r64_ov, r64_od, r64_occ, r64_ir);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
